// File: rtl/student_sched_fsm.sv
// Daily schedule state machine for a student: moves between sleeping,
// eating, commuting, lectures, study and leisure activities based on
// level condition flags, with timed LECTURE/STUDY visits, an awake-time
// limit that forces SLEEP, and a wake-up (day) counter.
module student_sched_fsm #(
  parameter int CNT_W     = 4,
  parameter int DAY_W     = 8,
  parameter int MAX_AWAKE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm,
  input  logic             bus,
  input  logic             hungry,
  input  logic             lecture,
  input  logic             tired,
  input  logic             homework,
  input  logic             design_work,
  input  logic             brain_no_work,
  input  logic             energy,
  input  logic [CNT_W-1:0] num_lectures,
  input  logic [CNT_W-1:0] num_assignments,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] work_count,
  output logic [DAY_W-1:0] day_count,
  output logic             forced_sleep
);

  localparam int AW = (MAX_AWAKE > 1) ? $clog2(MAX_AWAKE) : 1;

  typedef enum logic [3:0] {
    SLEEP       = 4'd0,
    EAT         = 4'd1,
    BUS         = 4'd2,
    LECTURE     = 4'd3,
    TIM_HORTONS = 4'd4,
    STUDY       = 4'd5,
    DESIGN_TEAM = 4'd6,
    NETFLIX     = 4'd7,
    GYM         = 4'd8,
    SOCIALIZE   = 4'd9
  } state_t;

  state_t           state;
  state_t           normal_nxt;
  state_t           state_nxt;
  logic [AW-1:0]    awake;
  logic [CNT_W-1:0] lect_lim;
  logic [CNT_W-1:0] study_lim;
  logic             lect_done;
  logic             study_done;
  logic             timeout;
  logic             force_pulse;
  logic             visit_stay;

  // A zero limit behaves as a single-cycle visit; limits are compared live.
  assign lect_lim   = (num_lectures == '0) ? CNT_W'(1) : num_lectures;
  assign study_lim  = (num_assignments == '0) ? CNT_W'(1) : num_assignments;
  assign lect_done  = (work_count >= (lect_lim - CNT_W'(1)));
  assign study_done = (work_count >= (study_lim - CNT_W'(1)));

  assign state_out = state;

  // Rule-based next state, before the awake-timeout override.
  always_comb begin
    normal_nxt = state;
    case (state)
      SLEEP: begin
        if (alarm && bus)         normal_nxt = BUS;
        else if (alarm && hungry) normal_nxt = EAT;
      end
      EAT:         if (bus) normal_nxt = BUS;
      BUS: begin
        if (lecture)            normal_nxt = LECTURE;
        else if (homework)      normal_nxt = TIM_HORTONS;
        else if (energy)        normal_nxt = GYM;
        else if (brain_no_work) normal_nxt = NETFLIX;
        else                    normal_nxt = SOCIALIZE;
      end
      LECTURE:     if (lect_done) normal_nxt = STUDY;
      TIM_HORTONS: normal_nxt = STUDY;
      STUDY:       if (study_done) normal_nxt = design_work ? DESIGN_TEAM : EAT;
      DESIGN_TEAM: if (hungry && !design_work) normal_nxt = EAT;
      NETFLIX:     if (tired) normal_nxt = SLEEP;
      SOCIALIZE:   if (tired) normal_nxt = SLEEP;
      GYM:         if (tired || !energy) normal_nxt = SLEEP;
      default:     normal_nxt = SLEEP;
    endcase
  end

  // Awake timeout overrides every rule; the pulse only marks a changed outcome.
  always_comb begin
    timeout     = (state != SLEEP) && (awake == AW'(MAX_AWAKE - 1));
    state_nxt   = timeout ? SLEEP : normal_nxt;
    force_pulse = timeout && (normal_nxt != SLEEP);
    visit_stay  = (state_nxt == state) && ((state == LECTURE) || (state == STUDY));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SLEEP;
    else     state <= state_nxt;
  end

  // Visit, awake and day counters plus the forced-sleep pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_count   <= '0;
      awake        <= '0;
      day_count    <= '0;
      forced_sleep <= 1'b0;
    end else begin
      work_count   <= visit_stay ? (work_count + CNT_W'(1)) : '0;
      awake        <= ((state == SLEEP) || (state_nxt == SLEEP)) ? '0 : (awake + AW'(1));
      day_count    <= ((state == SLEEP) && (state_nxt != SLEEP)) ? (day_count + DAY_W'(1))
                                                                 : day_count;
      forced_sleep <= force_pulse;
    end
  end

endmodule

// File: tb/tb_student_sched_fsm.sv
// Scoreboard bench for student_sched_fsm: a stimulus process drives inputs
// and pushes the reference model's predicted outputs; a monitor pops and
// compares them one cycle later.
module tb_student_sched_fsm;

  localparam int CNT_W = 4;
  localparam int DAYW  = 2;
  localparam int MAXA  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             alarm, bus, hungry, lecture, tired, homework;
  logic             design_work, brain_no_work, energy;
  logic [CNT_W-1:0] num_lectures, num_assignments;
  logic [3:0]       state_out;
  logic [CNT_W-1:0] work_count;
  logic [DAYW-1:0]  day_count;
  logic             forced_sleep;

  student_sched_fsm #(.CNT_W(CNT_W), .DAY_W(DAYW), .MAX_AWAKE(MAXA)) dut (
    .clk(clk), .rst(rst), .alarm(alarm), .bus(bus), .hungry(hungry),
    .lecture(lecture), .tired(tired), .homework(homework),
    .design_work(design_work), .brain_no_work(brain_no_work), .energy(energy),
    .num_lectures(num_lectures), .num_assignments(num_assignments),
    .state_out(state_out), .work_count(work_count), .day_count(day_count),
    .forced_sleep(forced_sleep)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int wc;
    int day;
    int fs;
  } exp_t;

  exp_t expq[$];
  int   npass  = 0;
  int   ntotal = 0;

  // Reference model: activity codes, cycles spent in the visit, awake cycles.
  int m_st = 0, m_elapsed = 0, m_awake = 0, m_day = 0, m_fs = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    int nxt;
    int lim;
    if (rst) begin
      m_st = 0; m_elapsed = 0; m_awake = 0; m_day = 0; m_fs = 0;
    end else begin
      nxt = m_st;
      case (m_st)
        0: if (alarm && bus) nxt = 2; else if (alarm && hungry) nxt = 1;
        1: if (bus) nxt = 2;
        2: nxt = lecture ? 3 : homework ? 4 : energy ? 8 : brain_no_work ? 7 : 9;
        3: begin
          lim = (num_lectures == 0) ? 1 : int'(num_lectures);
          if (m_elapsed + 1 >= lim) nxt = 5;
        end
        4: nxt = 5;
        5: begin
          lim = (num_assignments == 0) ? 1 : int'(num_assignments);
          if (m_elapsed + 1 >= lim) nxt = design_work ? 6 : 1;
        end
        6: if (hungry && !design_work) nxt = 1;
        7, 9: if (tired) nxt = 0;
        8: if (tired || !energy) nxt = 0;
        default: nxt = 0;
      endcase
      m_fs = 0;
      // m_awake counts completed awake cycles before this one; the 8th forces sleep.
      if (m_st != 0 && m_awake + 1 == MAXA) begin
        if (nxt != 0) m_fs = 1;
        nxt = 0;
      end
      if (m_st == 0 && nxt != 0) m_day = (m_day + 1) % (1 << DAYW);
      if (nxt == m_st && (nxt == 3 || nxt == 5)) m_elapsed++;
      else m_elapsed = 0;
      if (m_st == 0 || nxt == 0) m_awake = 0;
      else m_awake++;
      m_st = nxt;
    end
  endtask

  // One clock: predict, queue, then move to the next negedge.
  task automatic tick();
    exp_t e;
    model_step();
    e.st = m_st; e.wc = m_elapsed; e.day = m_day; e.fs = m_fs;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; alarm = 0; bus = 0; hungry = 0; lecture = 0; tired = 0;
    homework = 0; design_work = 0; brain_no_work = 0; energy = 0;
  endtask

  // Monitor: compare every registered output one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        chk("no_expectation", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("state_out", int'(state_out), e.st);
        chk("work_count", int'(work_count), e.wc);
        chk("day_count", int'(day_count), e.day);
        chk("forced_sleep", int'(forced_sleep), e.fs);
      end
    end
  end

  initial begin
    idle();
    num_lectures = 4'd3; num_assignments = 4'd0;
    // Reset, wake on bus, lecture of 3 cycles, 1-cycle study, then eat.
    rst = 1; tick(); tick();
    idle(); alarm = 1; bus = 1; tick();
    idle(); lecture = 1; tick();
    idle(); tick(); tick(); tick(); tick(); tick();
    // Forced sleep while parked in EAT.
    rst = 1; tick(); idle();
    alarm = 1; hungry = 1; tick();
    idle(); repeat (10) tick();
    // Tired-driven sleep coinciding with the timeout: no pulse.
    alarm = 1; bus = 1; tick();
    idle(); repeat (6) tick();
    tired = 1; tick();
    idle(); tick();
    // Four wake/sleep days, day_count wraps.
    rst = 1; tick();
    for (int unsigned d = 0; d < 4; d++) begin
      idle(); alarm = 1; bus = 1; tick();
      idle(); tick();
      tired = 1; tick();
    end
    // Reset in mid-STUDY.
    num_lectures = 4'd1; num_assignments = 4'd5;
    idle(); alarm = 1; bus = 1; tick();
    idle(); lecture = 1; tick();
    idle(); tick(); tick(); tick();
    rst = 1; tick();
    // BUS with nothing set -> SOCIALIZE; BUS with energy -> GYM, energy drop -> SLEEP.
    idle(); alarm = 1; bus = 1; tick();
    idle(); tick(); tired = 1; tick();
    idle(); alarm = 1; bus = 1; tick();
    idle(); energy = 1; tick(); tick();
    energy = 0; tick(); tick();
    // Randomized phase with live limit changes and occasional reset.
    for (int unsigned i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      alarm         = $urandom_range(0, 1);
      bus           = $urandom_range(0, 1);
      hungry        = $urandom_range(0, 1);
      lecture       = $urandom_range(0, 1);
      tired         = ($urandom_range(0, 3) == 0);
      homework      = $urandom_range(0, 1);
      design_work   = $urandom_range(0, 1);
      brain_no_work = $urandom_range(0, 1);
      energy        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) num_lectures = CNT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) num_assignments = CNT_W'($urandom_range(0, 15));
      tick();
    end
    idle();
    if (expq.size() != 0) chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/student_sched_fsm.md
STUDENT_SCHED_FSM -- requirements
Module: student_sched_fsm

Interface
REQ-001 Parameter CNT_W, default 4: width of num_lectures, num_assignments and work_count.
REQ-002 Parameter DAY_W, default 8: width of day_count.
REQ-003 Parameter MAX_AWAKE, default 64 (legal range 2..65535): the awake cycle at which the block forces SLEEP.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 alarm, bus, hungry, lecture, tired, homework, design_work, brain_no_work, energy  input  1 each  level condition flags, sampled every cycle.
REQ-007 num_lectures  input  CNT_W  lecture cycles per LECTURE visit; a value of 0 is treated as 1.
REQ-008 num_assignments  input  CNT_W  study cycles per STUDY visit; a value of 0 is treated as 1.
REQ-009 state_out  output  4  current state code.
REQ-010 work_count  output  CNT_W  cycles spent so far in the current LECTURE or STUDY visit.
REQ-011 day_count  output  DAY_W  number of SLEEP exits, modulo 2^DAY_W.
REQ-012 forced_sleep  output  1  one-cycle pulse, high in the first SLEEP cycle caused by the awake timeout.

Function
REQ-013 State codes: SLEEP=0, EAT=1, BUS=2, LECTURE=3, TIM_HORTONS=4, STUDY=5, DESIGN_TEAM=6, NETFLIX=7, GYM=8, SOCIALIZE=9; codes 10-15 go to SLEEP on the next cycle.
REQ-014 Every output is registered, and next state is fully assigned on every path: no latches, and a state holds unless a rule below fires.
REQ-015 SLEEP: alarm&bus -> BUS; else alarm&hungry -> EAT; else hold.
REQ-016 EAT: bus -> BUS.
REQ-017 BUS, first match wins: lecture -> LECTURE; homework -> TIM_HORTONS; energy -> GYM; brain_no_work -> NETFLIX; otherwise SOCIALIZE. BUS always lasts exactly 1 cycle.
REQ-018 LECTURE: stays exactly max(num_lectures,1) cycles, then -> STUDY.
REQ-019 TIM_HORTONS: stays 1 cycle, then -> STUDY.
REQ-020 STUDY: stays exactly max(num_assignments,1) cycles, then -> DESIGN_TEAM if design_work, else -> EAT.
REQ-021 The STUDY exit branch samples design_work in the last STUDY cycle only.
REQ-022 DESIGN_TEAM: hungry & !design_work -> EAT.
REQ-023 NETFLIX and SOCIALIZE: tired -> SLEEP.
REQ-024 GYM: tired | !energy -> SLEEP.
REQ-025 work_count is 0 in the first cycle of each LECTURE or STUDY visit.
REQ-026 work_count increments by 1 per cycle while in that visit.
REQ-027 work_count clears to 0 on the exit edge and is 0 in all other states.
REQ-028 num_lectures and num_assignments are compared live each cycle (exit when work_count >= limit-1); if a limit drops below work_count+1 mid-visit, the exit takes effect at once.
REQ-029 The awake counter (internal, width ceil(log2(MAX_AWAKE))) is 0 in SLEEP.
REQ-030 The awake counter increments once per non-SLEEP cycle.
REQ-031 In a non-SLEEP cycle with awake counter == MAX_AWAKE-1, the next state is SLEEP, overriding every rule above.
REQ-032 forced_sleep pulses only when the override of REQ-031 changed the outcome, i.e. the normal next state was not SLEEP; a simultaneous tired-driven SLEEP entry gives no pulse.
REQ-033 A forced exit from LECTURE or STUDY clears work_count.
REQ-034 day_count increments on each SLEEP->non-SLEEP transition and wraps from 2^DAY_W-1 to 0.

Reset
REQ-035 While rst=1 at a rising edge: state=SLEEP, work_count=0, day_count=0, awake counter=0, forced_sleep=0.
REQ-036 rst takes priority over all transitions, including mid-LECTURE/STUDY and in the timeout cycle; all inputs are ignored during reset.

Verification
REQ-037 Reset, then alarm=1 bus=1 for 1 cycle -> state_out 0->2; day_count=1; next cycle with lecture=1 -> state_out=3.
REQ-038 num_lectures=3, LECTURE entered -> state_out=3 for 3 cycles with work_count 0,1,2, then state_out=5 with work_count=0; num_assignments=0, design_work=0 -> STUDY for 1 cycle, then EAT.
REQ-039 MAX_AWAKE=8, path SLEEP->EAT held (bus=0) -> exactly 8 non-SLEEP cycles, then state_out=0 with forced_sleep=1 for 1 cycle; with tired=1 in SOCIALIZE at the same cycle -> forced_sleep=0.
REQ-040 DAY_W=2, four alarm-wake / tired-sleep cycles -> day_count 1,2,3,0.
REQ-041 rst asserted in a cycle where state_out=5 and work_count=2 -> next cycle state_out=0, work_count=0, day_count=0.
REQ-042 BUS with lecture=0 homework=0 energy=0 brain_no_work=0 -> SOCIALIZE; GYM with energy dropping to 0 -> SLEEP next cycle.
